// File: rtl/vis_pkg.sv
// Shared types and helpers for the vision marker overlay.
package vis_pkg;
  localparam int COORD_W = 11;
  localparam int PIX_W   = 24;

  typedef logic [COORD_W-1:0]      coord_t;
  typedef logic signed [COORD_W:0] delta_t;
  typedef logic [23:0]             dist2_t;
  typedef logic [PIX_W-1:0]        pixel_t;

  localparam coord_t COORD_MAX = '1;

  function automatic coord_t sat_inc(input coord_t v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/vis_marker_hit.sv
// Per-marker ring hit test, two registered stages (delta, then distance compare).
// Optional crosshair overlay when VIS_MARKER_CROSSHAIR_EN is defined.
module vis_marker_hit
  import vis_pkg::*;
#(
  parameter int RADIUS = 8,
  parameter int THICK  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] xc,
  input  logic [COORD_W-1:0] yc,
  input  logic               en,
  output logic               hit
);
  localparam dist2_t OUTER_SQ = dist2_t'(RADIUS * RADIUS);
  localparam dist2_t INNER_SQ = dist2_t'((RADIUS - THICK) * (RADIUS - THICK));

  delta_t dx_reg;
  delta_t dy_reg;
  logic   en_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      dx_reg <= '0;
      dy_reg <= '0;
      en_reg <= 1'b0;
    end else begin
      dx_reg <= $signed({1'b0, x}) - $signed({1'b0, xc});
      dy_reg <= $signed({1'b0, y}) - $signed({1'b0, yc});
      en_reg <= en;
    end
  end

  // Widen before squaring; the sum of two squares of |d|<=2047 fits 24 bits.
  logic signed [23:0] dx_w;
  logic signed [23:0] dy_w;
  dist2_t             d2;
  logic               ring;
  logic               mark;

  assign dx_w = 24'(dx_reg);
  assign dy_w = 24'(dy_reg);
  assign d2   = dx_w * dx_w + dy_w * dy_w;
  assign ring = (d2 <= OUTER_SQ) && (d2 > INNER_SQ);

`ifdef VIS_MARKER_CROSSHAIR_EN
  localparam delta_t RAD_D = delta_t'(RADIUS);
  delta_t adx;
  delta_t ady;
  logic   cross;
  assign adx   = dx_reg[COORD_W] ? -dx_reg : dx_reg;
  assign ady   = dy_reg[COORD_W] ? -dy_reg : dy_reg;
  assign cross = ((dy_reg == '0) && (adx <= RAD_D)) || ((dx_reg == '0) && (ady <= RAD_D));
  assign mark  = ring | cross;
`else
  assign mark  = ring;
`endif

  always_ff @(posedge clk) begin
    if (rst) hit <= 1'b0;
    else     hit <= en_reg & mark;
  end
endmodule

// File: rtl/vis_multi_marker.sv
// Multi-marker ring overlay on a live video stream, 3-cycle latency on all outputs.
// Define VIS_MARKER_CROSSHAIR_EN to add a crosshair to each enabled marker.
module vis_multi_marker
  import vis_pkg::*;
#(
  parameter int          IMG_W  = 64,
  parameter int          IMG_H  = 64,
  parameter int          N_MARK = 4,
  parameter int          RADIUS = 8,
  parameter int          THICK  = 1,
  parameter logic [23:0] COLOR  = 24'hFF0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      de,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic [COORD_W*N_MARK-1:0] x_center,
  input  logic [COORD_W*N_MARK-1:0] y_center,
  input  logic [N_MARK-1:0]         mark_en,
  input  logic [PIX_W-1:0]          pixel_in,
  output logic                      de_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic [PIX_W-1:0]          pixel_out
);
  if (N_MARK < 1 || N_MARK > 8 || RADIUS < 1 || RADIUS > 255 || THICK < 1 || THICK > RADIUS ||
      IMG_W < 1 || IMG_W > 2047 || IMG_H < 1 || IMG_H > 2047) begin : g_bad_param
    $error("vis_multi_marker: parameter out of range");
  end

  coord_t                    x_reg;
  coord_t                    y_reg;
  logic                      vsync_prev;
  logic                      de_prev;
  logic [COORD_W*N_MARK-1:0] xc_lat;
  logic [COORD_W*N_MARK-1:0] yc_lat;
  logic [N_MARK-1:0]         en_lat;
  logic                      vs_rise;
  logic                      de_fall;

  assign vs_rise = vsync & ~vsync_prev;
  assign de_fall = ~de & de_prev;

  // Frame start wins over a coincident end of line.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg      <= '0;
      y_reg      <= '0;
      vsync_prev <= 1'b0;
      de_prev    <= 1'b0;
      xc_lat     <= '0;
      yc_lat     <= '0;
      en_lat     <= '0;
    end else begin
      vsync_prev <= vsync;
      de_prev    <= de;
      if (vs_rise) begin
        x_reg  <= '0;
        y_reg  <= '0;
        xc_lat <= x_center;
        yc_lat <= y_center;
        en_lat <= mark_en;
      end else if (de_fall) begin
        x_reg <= '0;
        y_reg <= sat_inc(y_reg);
      end else if (de) begin
        x_reg <= sat_inc(x_reg);
      end
    end
  end

  logic [N_MARK-1:0] hit;

  for (genvar gi = 0; gi < N_MARK; gi++) begin : g_mark
    vis_marker_hit #(
      .RADIUS(RADIUS),
      .THICK (THICK)
    ) u_hit (
      .clk(clk),
      .rst(rst),
      .x  (x_reg),
      .y  (y_reg),
      .xc (xc_lat[gi*COORD_W +: COORD_W]),
      .yc (yc_lat[gi*COORD_W +: COORD_W]),
      .en (en_lat[gi]),
      .hit(hit[gi])
    );
  end

  logic [1:0] de_d;
  logic [1:0] hs_d;
  logic [1:0] vs_d;
  pixel_t     pix_d1;
  pixel_t     pix_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      de_d      <= '0;
      hs_d      <= '0;
      vs_d      <= '0;
      pix_d1    <= '0;
      pix_d2    <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      pixel_out <= '0;
    end else begin
      de_d      <= {de_d[0], de};
      hs_d      <= {hs_d[0], hsync};
      vs_d      <= {vs_d[0], vsync};
      pix_d1    <= pixel_in;
      pix_d2    <= pix_d1;
      de_out    <= de_d[1];
      hsync_out <= hs_d[1];
      vsync_out <= vs_d[1];
      pixel_out <= (de_d[1] && (|hit)) ? COLOR : pix_d2;
    end
  end
endmodule

// File: tb/tb_vis_multi_marker.sv
// Directed frame sequence with random pixels/centres, checked against a per-pixel geometric model.
module tb_vis_multi_marker;
  localparam int          N     = 4;
  localparam int          R     = 8;
  localparam int          T     = 1;
  localparam logic [23:0] COLOR = 24'hFF0000;

  logic          clk = 1'b0;
  logic          rst, de, hsync, vsync;
  logic [11*N-1:0] x_center, y_center;
  logic [N-1:0]  mark_en;
  logic [23:0]   pixel_in;
  logic          de_out, hsync_out, vsync_out;
  logic [23:0]   pixel_out;

  always #5 clk = ~clk;

  vis_multi_marker #(
    .IMG_W(64), .IMG_H(64), .N_MARK(N), .RADIUS(R), .THICK(T), .COLOR(COLOR)
  ) dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync),
    .x_center(x_center), .y_center(y_center), .mark_en(mark_en), .pixel_in(pixel_in),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .pixel_out(pixel_out)
  );

  typedef struct {
    logic        de, hs, vs;
    logic [23:0] pin, pexp;
    int          spot, px, py;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cx[N], cy[N];
  logic [N-1:0] cen;
  int          m_xc[N], m_yc[N];
  logic [N-1:0] m_en;
  logic        prev_vs;
  int          spot[64][64];  // 0 none, 1 must be COLOR, 2 must equal pixel_in

  task automatic chk(input string tag, input int px, input int py, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at (%0d,%0d): observed %06h expected %06h", tag, px, py, obs, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(input int px, input int py, input logic [23:0] pin);
    for (int i = 0; i < N; i++) begin
      if (m_en[i]) begin
        int dx, dy, d2;
        dx = px - m_xc[i];
        dy = py - m_yc[i];
        d2 = dx * dx + dy * dy;
        if (d2 <= R * R && d2 > (R - T) * (R - T)) return COLOR;
`ifdef VIS_MARKER_CROSSHAIR_EN
        if ((dy == 0 && dx <= R && dx >= -R) || (dx == 0 && dy <= R && dy >= -R)) return COLOR;
`endif
      end
    end
    return pin;
  endfunction

  task automatic drive_centres();
    for (int i = 0; i < N; i++) begin
      x_center[i*11 +: 11] = cx[i][10:0];
      y_center[i*11 +: 11] = cy[i][10:0];
    end
    mark_en = cen;
  endtask

  task automatic step(input logic d, input logic h, input logic v, input logic [23:0] p, input int px, input int py);
    ent_t e;
    if (v && !prev_vs) begin
      for (int i = 0; i < N; i++) begin
        m_xc[i] = cx[i];
        m_yc[i] = cy[i];
      end
      m_en = cen;
    end
    prev_vs = v;
    e.de = d; e.hs = h; e.vs = v; e.pin = p; e.px = px; e.py = py;
    e.pexp = d ? model_pix(px, py, p) : p;
    e.spot = d ? spot[px][py] : 0;
    q.push_back(e);
    de = d; hsync = h; vsync = v; pixel_in = p;
    drive_centres();
    @(posedge clk); #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("de_out", e.px, e.py, 24'(de_out), 24'(e.de));
      chk("hsync_out", e.px, e.py, 24'(hsync_out), 24'(e.hs));
      chk("vsync_out", e.px, e.py, 24'(vsync_out), 24'(e.vs));
      chk("pixel_out", e.px, e.py, pixel_out, e.pexp);
      if (e.spot == 1)      chk("spot_color", e.px, e.py, pixel_out, COLOR);
      else if (e.spot == 2) chk("spot_pass", e.px, e.py, pixel_out, e.pin);
    end
  endtask

  task automatic do_reset(input int n);
    ent_t z;
    rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("rst_de_out", 0, 0, 24'(de_out), 24'h0);
      chk("rst_hsync_out", 0, 0, 24'(hsync_out), 24'h0);
      chk("rst_vsync_out", 0, 0, 24'(vsync_out), 24'h0);
      chk("rst_pixel_out", 0, 0, pixel_out, 24'h0);
    end
    rst = 1'b0;
    q.delete();
    z = '{default: 0};
    q.push_back(z);
    q.push_back(z);
    m_en = '0;
    prev_vs = 1'b0;
  endtask

  task automatic clear_spots();
    for (int a = 0; a < 64; a++)
      for (int b = 0; b < 64; b++) spot[a][b] = 0;
  endtask

  task automatic run_frame(input bit grey, input int change_line, input int rst_line);
    repeat (4) step(1'b0, 1'b0, 1'b1, 24'($urandom), 0, 0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
    for (int r = 0; r < 64; r++) begin
      if (r == change_line) begin
        cx[0] = 40;
        cy[0] = 20;
      end
      if (r == rst_line) do_reset(2);
      repeat (3) step(1'b0, 1'b1, 1'b0, 24'($urandom), 0, 0);
      repeat (3) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
      for (int c = 0; c < 64; c++) step(1'b1, 1'b0, 1'b0, grey ? 24'h808080 : 24'($urandom), c, r);
      repeat (2) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
    end
  endtask

  initial begin
    rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; pixel_in = '0;
    for (int i = 0; i < N; i++) begin cx[i] = 0; cy[i] = 0; end
    cen = '0; m_en = '0; prev_vs = 1'b0;
    drive_centres();
    clear_spots();
    do_reset(2);

    // Single ring on grey background
    cx[0] = 28; cy[0] = 37; cen = 4'b0001;
    spot[36][37] = 1; spot[28][29] = 1; spot[20][37] = 1; spot[37][37] = 2;
`ifdef VIS_MARKER_CROSSHAIR_EN
    spot[28][37] = 1;
`else
    spot[28][37] = 2;
`endif
    run_frame(1'b1, -1, -1);

    // Two neighbouring markers
    clear_spots();
    cx[0] = 10; cy[0] = 10; cx[1] = 14; cy[1] = 10; cen = 4'b0011;
    spot[18][10] = 1;
`ifdef VIS_MARKER_CROSSHAIR_EN
    spot[12][10] = 1;
`else
    spot[12][10] = 2;
`endif
    run_frame(1'b0, -1, -1);

    // Mid-frame centre change only applies from the next frame
    clear_spots();
    cx[0] = 28; cy[0] = 37; cen = 4'b0001;
    spot[28][29] = 1; spot[20][37] = 1; spot[36][37] = 1;
    run_frame(1'b0, 30, -1);
    clear_spots();
    spot[48][20] = 1; spot[36][37] = 2; spot[20][37] = 2;
    run_frame(1'b0, -1, -1);

    // Corner marker, off-image marker, far-corner marker
    clear_spots();
    cx[0] = 0; cy[0] = 0; cx[1] = 2047; cy[1] = 2047; cx[2] = 63; cy[2] = 63; cen = 4'b0111;
    spot[8][0] = 1; spot[0][8] = 1; spot[63][0] = 2;
    run_frame(1'b0, -1, -1);

    // Reset mid-frame, markers return after the next frame start
    clear_spots();
    cx[0] = 28; cy[0] = 37; cx[1] = 0; cy[1] = 0; cx[2] = 0; cy[2] = 0; cen = 4'b0001;
    spot[28][29] = 1; spot[36][37] = 2; spot[20][37] = 2;
    run_frame(1'b0, -1, 32);
    clear_spots();
    spot[36][37] = 1;
`ifdef VIS_MARKER_CROSSHAIR_EN
    spot[28][37] = 1;
`else
    spot[28][37] = 2;
`endif
    run_frame(1'b0, -1, -1);

    // Random centres (including partly off-image) and enables
    repeat (2) begin
      clear_spots();
      for (int i = 0; i < N; i++) begin
        cx[i] = $urandom_range(75, 0);
        cy[i] = $urandom_range(75, 0);
      end
      cen = N'($urandom);
      run_frame(1'b0, -1, -1);
    end

    repeat (4) step(1'b0, 1'b0, 1'b0, 24'($urandom), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
